cpu_fetch: RTL

CPU_FETCH -- requirements
Module: cpu_fetch

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/cpu_ilen.sv | 23 ++
 rtl/cpu_fetch.sv | 116 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch unit: FSM states, instruction lengths, HLT opcode.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_OP   = 3'd1,
    S_B2   = 3'd2,
    S_B3   = 3'd3,
    S_HOLD = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [1:0] LEN_1  = 2'd1;
  localparam logic [1:0] LEN_2  = 2'd2;
  localparam logic [1:0] LEN_3  = 2'd3;
  localparam logic [7:0] HLT_OP = 8'hFF;

  function automatic logic is_fetch(input state_t st);
    return (st == S_OP) || (st == S_B2) || (st == S_B3);
  endfunction

endpackage

// File: rtl/cpu_ilen.sv
// Combinational instruction-length decode from the opcode byte.
module cpu_ilen
  import cpu_pkg::*;
(
  input  logic [7:0] i_opcode,
  output logic [1:0] o_len
);

  // Middle opcode bits do not influence length.
  logic w_unused;
  assign w_unused = ^i_opcode[5:3];

  always_comb begin
    o_len = LEN_1;
    if (i_opcode[7:6] == 2'b00 &&
        (i_opcode[2:0] == 3'b100 || i_opcode[2:0] == 3'b110)) begin
      o_len = LEN_2;
    end else if (i_opcode[7:6] == 2'b01 && !i_opcode[0]) begin
      o_len = LEN_3;
    end
  end

endmodule

// File: rtl/cpu_fetch.sv
// Byte-serial instruction fetch: assembles 1-3 byte instructions and holds them for the decoder.
// Optional HLT stop is enabled by defining CPU_FETCH_HLT_EN.
module cpu_fetch
  import cpu_pkg::*;
(
  input  logic        CLK_I,
  input  logic        RSTN_I,
  output logic [13:0] MEM_ADDR_O,
  output logic        MEM_RD_O,
  input  logic        MEM_RDY_I,
  input  logic [7:0]  MEM_DATA_I,
  input  logic        PC_LD_I,
  input  logic [13:0] PC_LD_ADDR_I,
  output logic [7:0]  IR_O,
  output logic [7:0]  IMM_LO_O,
  output logic [7:0]  IMM_HI_O,
  output logic        INSTR_VLD_O,
  input  logic        INSTR_ACK_I,
  output logic [13:0] PC_O,
  output logic        HALT_O
);

  state_t      r_state;
  state_t      w_state_next;
  logic [13:0] r_pc;
  logic [7:0]  r_ir;
  logic [7:0]  r_imm_lo;
  logic [7:0]  r_imm_hi;
  logic        r_mem_rd;
  logic        r_vld;
  logic [7:0]  w_opcode;
  logic [1:0]  w_len;
  logic        w_hlt;
  logic        w_redirect;

  // In S_OP the opcode is still on the bus, so decode length from it directly.
  assign w_opcode   = (r_state == S_OP) ? MEM_DATA_I : r_ir;
  assign w_redirect = PC_LD_I && (r_state != S_RST);

  cpu_ilen u_ilen (
    .i_opcode (w_opcode),
    .o_len    (w_len)
  );

`ifdef CPU_FETCH_HLT_EN
  logic r_halt;
  assign w_hlt  = (r_ir == HLT_OP);
  assign HALT_O = r_halt;
`else
  assign w_hlt  = 1'b0;
  assign HALT_O = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RST:  w_state_next = S_OP;
      S_OP:   if (MEM_RDY_I) w_state_next = (w_len == LEN_1) ? S_HOLD : S_B2;
      S_B2:   if (MEM_RDY_I) w_state_next = (w_len == LEN_3) ? S_B3 : S_HOLD;
      S_B3:   if (MEM_RDY_I) w_state_next = S_HOLD;
      S_HOLD: if (INSTR_ACK_I) w_state_next = w_hlt ? S_HALT : S_OP;
      S_HALT: w_state_next = S_HALT;
      default: w_state_next = S_RST;
    endcase
    if (w_redirect) w_state_next = S_OP;
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      r_state  <= S_RST;
      r_pc     <= 14'h0000;
      r_ir     <= 8'h00;
      r_imm_lo <= 8'h00;
      r_imm_hi <= 8'h00;
      r_mem_rd <= 1'b0;
      r_vld    <= 1'b0;
`ifdef CPU_FETCH_HLT_EN
      r_halt   <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_mem_rd <= is_fetch(w_state_next);
      r_vld    <= (w_state_next == S_HOLD);
`ifdef CPU_FETCH_HLT_EN
      r_halt   <= (w_state_next == S_HALT);
`endif
      if (w_redirect) begin
        r_pc     <= PC_LD_ADDR_I;
        r_ir     <= 8'h00;
        r_imm_lo <= 8'h00;
        r_imm_hi <= 8'h00;
      end else if (is_fetch(r_state) && MEM_RDY_I) begin
        r_pc <= r_pc + 14'd1;
        case (r_state)
          S_OP: begin
            r_ir     <= MEM_DATA_I;
            r_imm_lo <= 8'h00;
            r_imm_hi <= 8'h00;
          end
          S_B2:    r_imm_lo <= MEM_DATA_I;
          S_B3:    r_imm_hi <= MEM_DATA_I;
          default: ;
        endcase
      end
    end
  end

  assign MEM_ADDR_O  = r_pc;
  assign MEM_RD_O    = r_mem_rd;
  assign INSTR_VLD_O = r_vld;
  assign IR_O        = r_ir;
  assign IMM_LO_O    = r_imm_lo;
  assign IMM_HI_O    = r_imm_hi;
  assign PC_O        = r_pc;

endmodule
